aim_sweep_ctrl: RTL
===================

AIM_SWEEP_CTRL -- requirements
Module: aim_sweep_ctrl

Interface
REQ-001 Parameter FRAMES_PER_STEP, default 8, frames between aim-position steps; legal range 1..63.
REQ-002 Parameter CENTER_POS, default 3, aim position index loaded at reset and on return to IDLE.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 startOfFrame  in  1  one-cycle pulse, once per VGA frame.
REQ-006 aim_req  in  1  level; player holds to aim.
REQ-007 fire_req  in  1  one-cycle pulse; player fires.
REQ-008 launch_busy  in  1  level from ball mover; high while ball in flight.
REQ-009 circular_ps  out  4  current aim position index, 0..6; drives the trajectory line generator.
REQ-010 line_en  out  1  trajectory line draw enable.
REQ-011 launch_pulse  out  1  one-cycle launch command to ball mover.
REQ-012 launch_index  out  4  aim position captured at fire; valid while launch_pulse=1 and held until next fire.
REQ-013 ctrl_state  out  3  encoded FSM state, for debug/score logic.

Function
REQ-014 All outputs SHALL be registered; input effects SHALL appear on outputs one clk after sampling.
REQ-015 FSM states SHALL be IDLE=0, SWEEP=1, FIRE=2, WAIT_ACK=3, FLIGHT=4; codes 5..7 SHALL go to IDLE next cycle.
REQ-016 IDLE: circular_ps=CENTER_POS, line_en=0; aim_req=1 -> SWEEP; fire_req ignored.
REQ-017 SWEEP: frame counter (6 bits) SHALL increment on each startOfFrame; when it equals FRAMES_PER_STEP-1 at startOfFrame it SHALL clear and circular_ps SHALL step one position in the current direction.
REQ-018 Sweep SHALL ping-pong: direction up after reset; at 6 going up it SHALL step to 5 and go down; at 0 going down it SHALL step to 1 and go up; circular_ps SHALL never leave 0..6.
REQ-019 SWEEP: fire_req=1 -> FIRE; else aim_req=0 -> IDLE (counter cleared, direction up).
REQ-020 fire_req and a step on the same cycle: fire SHALL win; launch_index SHALL equal the pre-step circular_ps and circular_ps SHALL not step.
REQ-021 fire_req and aim_req falling on the same cycle: fire SHALL win.
REQ-022 FIRE: lasts exactly one cycle; launch_pulse=1, launch_index latched; line_en=0; -> WAIT_ACK.
REQ-023 WAIT_ACK: hold until launch_busy=1 -> FLIGHT; launch_busy already high on entry SHALL advance next cycle.
REQ-024 FLIGHT: line_en=0, circular_ps frozen; launch_busy=0 -> IDLE.
REQ-025 fire_req SHALL be ignored in FIRE, WAIT_ACK and FLIGHT (no queuing).
REQ-026 line_en SHALL be 0 in every state other than SWEEP.

Reset
REQ-027 On reset=1 at a clk edge: state=IDLE, circular_ps=CENTER_POS, launch_index=CENTER_POS, line_en=0, launch_pulse=0, frame/blink counters=0, direction=up.
REQ-028 Reset mid-FIRE/WAIT_ACK/FLIGHT SHALL abort with no launch_pulse emitted after reset asserts; reset SHALL override all inputs.

Configuration
REQ-029 Macro AIM_SWEEP_BLINK_EN defined: in SWEEP, a 4-bit blink counter SHALL increment on each startOfFrame and line_en SHALL equal NOT blink_cnt[3] (8 frames on, 8 off); blink counter cleared on entry to SWEEP.
REQ-030 Macro undefined: no blink counter; line_en SHALL be 1 throughout SWEEP.

Verification
REQ-031 FRAMES_PER_STEP=2, aim_req held, 14 SOF pulses -> circular_ps sequence 3,4,5,6,5,4,3,2 (one step per 2 SOF), never outside 0..6.
REQ-032 Sweep at circular_ps=5, fire_req on a step cycle -> launch_pulse=1 for exactly one cycle, launch_index=5, circular_ps stays 5, line_en=0.
REQ-033 After fire, launch_busy high 3 cycles later then low 100 cycles later -> ctrl_state 2,3,3,3,4...4,0; circular_ps=3 in IDLE.
REQ-034 fire_req pulses during WAIT_ACK and FLIGHT -> no additional launch_pulse.
REQ-035 reset asserted in WAIT_ACK -> next cycle ctrl_state=0, circular_ps=3, launch_pulse=0, line_en=0.
REQ-036 With AIM_SWEEP_BLINK_EN, 32 SOF in SWEEP -> line_en high SOF 0..7, low 8..15, high 16..23, low 24..31; without macro -> line_en constant 1.

Source files
------------

// File: rtl/aim_sweep_ctrl.sv
// aim_sweep_ctrl: aiming sweep controller for the ball launcher.
// The aim position ping-pongs across positions 0..6, moving one step every
// FRAMES_PER_STEP frames. A fire request captures the position and issues a
// one-cycle launch command, then the controller waits out the ball flight.
// Optional build macro AIM_SWEEP_BLINK_EN: the trajectory line blinks while
// sweeping (8 frames on, 8 frames off) instead of staying on.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | aim centred, line off, waiting for aim_req
// SWEEP    | aim position sweeping, line drawn, waiting for fire/release
// FIRE     | one-cycle launch command with captured aim position
// WAIT_ACK | waiting for the ball mover to report launch_busy
// FLIGHT   | ball in flight, aim frozen, waiting for launch_busy to drop
module aim_sweep_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned CENTER_POS      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       aim_req,
  input  logic       fire_req,
  input  logic       launch_busy,
  output logic [3:0] circular_ps,
  output logic       line_en,
  output logic       launch_pulse,
  output logic [3:0] launch_index,
  output logic [2:0] ctrl_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SWEEP    = 3'd1,
    S_FIRE     = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_FLIGHT   = 3'd4
  } state_t;

  localparam logic [5:0] FRAME_LAST = 6'(FRAMES_PER_STEP - 1);
  localparam logic [3:0] CENTER     = 4'(CENTER_POS);
  localparam logic [3:0] POS_MAX    = 4'd6;

  state_t     state;
  logic [5:0] frame_cnt;
  logic       dir_up;

`ifdef AIM_SWEEP_BLINK_EN
  logic [3:0] blink_cnt;
  logic [3:0] blink_inc;

  // Blink count after this frame's increment, so line_en tracks blink_cnt.
  assign blink_inc = blink_cnt + 4'd1;
`endif

  assign ctrl_state = state;

  // Sweep FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      circular_ps  <= CENTER;
      launch_index <= CENTER;
      line_en      <= 1'b0;
      launch_pulse <= 1'b0;
      frame_cnt    <= '0;
      dir_up       <= 1'b1;
`ifdef AIM_SWEEP_BLINK_EN
      blink_cnt    <= '0;
`endif
    end else begin
      launch_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          circular_ps <= CENTER;
          frame_cnt   <= '0;
          dir_up      <= 1'b1;
          line_en     <= 1'b0;
          if (aim_req) begin
            state   <= S_SWEEP;
            line_en <= 1'b1;
`ifdef AIM_SWEEP_BLINK_EN
            blink_cnt <= '0;
`endif
          end
        end

        S_SWEEP: begin
          if (fire_req) begin
            // Fire beats a pending step and a released aim on the same cycle.
            state        <= S_FIRE;
            launch_pulse <= 1'b1;
            launch_index <= circular_ps;
            line_en      <= 1'b0;
          end else if (!aim_req) begin
            state       <= S_IDLE;
            circular_ps <= CENTER;
            frame_cnt   <= '0;
            dir_up      <= 1'b1;
            line_en     <= 1'b0;
          end else begin
            if (startOfFrame) begin
              if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                if (dir_up) begin
                  if (circular_ps >= POS_MAX) begin
                    circular_ps <= POS_MAX - 4'd1;
                    dir_up      <= 1'b0;
                  end else begin
                    circular_ps <= circular_ps + 4'd1;
                  end
                end else begin
                  if (circular_ps == 4'd0) begin
                    circular_ps <= 4'd1;
                    dir_up      <= 1'b1;
                  end else begin
                    circular_ps <= circular_ps - 4'd1;
                  end
                end
              end else begin
                frame_cnt <= frame_cnt + 6'd1;
              end
            end
`ifdef AIM_SWEEP_BLINK_EN
            if (startOfFrame) begin
              blink_cnt <= blink_inc;
              line_en   <= ~blink_inc[3];
            end else begin
              line_en   <= ~blink_cnt[3];
            end
`else
            line_en <= 1'b1;
`endif
          end
        end

        S_FIRE: begin
          line_en <= 1'b0;
          state   <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          line_en <= 1'b0;
          if (launch_busy) begin
            state <= S_FLIGHT;
          end
        end

        S_FLIGHT: begin
          line_en <= 1'b0;
          if (!launch_busy) begin
            state       <= S_IDLE;
            circular_ps <= CENTER;
            frame_cnt   <= '0;
            dir_up      <= 1'b1;
          end
        end

        default: begin
          state       <= S_IDLE;
          circular_ps <= CENTER;
          frame_cnt   <= '0;
          dir_up      <= 1'b1;
          line_en     <= 1'b0;
        end
      endcase
    end
  end

endmodule
